// File: rtl/robs_control_if.sv
// Signal bundle between the Robertson multiplier controller and its datapath/host.
// The cycles field exists only when ROBS_CTRL_CYCLES_EN is defined.
interface robs_control_if;
  logic        start;
  logic        zr;
  logic        zq;
  logic [14:0] c;
  logic        ready;
  logic        done;
`ifdef ROBS_CTRL_CYCLES_EN
  logic [5:0]  cycles;
`endif

  modport master (
    output start,
    output zr,
    output zq,
    input  c,
    input  ready,
    input  done
`ifdef ROBS_CTRL_CYCLES_EN
    , input cycles
`endif
  );

  modport slave (
    input  start,
    input  zr,
    input  zq,
    output c,
    output ready,
    output done
`ifdef ROBS_CTRL_CYCLES_EN
    , output cycles
`endif
  );
endinterface

// File: rtl/robs_control.sv
// Moore controller sequencing an 8-iteration Robertson signed multiply on robs_datapath.
// Optional feature macro ROBS_CTRL_CYCLES_EN adds a per-operation cycle count output.
module robs_control (
  input  logic          clk,
  input  logic          reset,
  robs_control_if.slave bus
);

  localparam int unsigned B_LOAD_Y  = 0;
  localparam int unsigned B_CNT_RST = 1;
  localparam int unsigned B_CLR_A   = 2;
  localparam int unsigned B_LOAD_X  = 3;
  localparam int unsigned B_RH_LO   = 4;
  localparam int unsigned B_RH_HI   = 5;
  localparam int unsigned B_RL_MUX  = 6;
  localparam int unsigned B_X_MUX   = 7;
  localparam int unsigned B_LOAD_RH = 8;
  localparam int unsigned B_LOAD_RL = 9;
  localparam int unsigned B_ADD     = 10;
  localparam int unsigned B_ARITH   = 11;
  localparam int unsigned B_SHIFT   = 12;
  localparam int unsigned B_CNT_EN  = 13;
  localparam int unsigned B_LOAD_A  = 14;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_LOADR = 4'd2,
    S_TEST  = 4'd3,
    S_ADD   = 4'd4,
    S_SHIFT = 4'd5,
    S_WRITE = 4'd6,
    S_STORE = 4'd7,
    S_CHECK = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [14:0] c_q, c_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  // Outputs are registered from the next state so they always describe the current state.
  function automatic logic [14:0] ctrl_word(input state_t s, input logic [2:0] it);
    logic [14:0] w;
    w = 15'd0;
    case (s)
      S_INIT: begin
        w[B_LOAD_Y]  = 1'b1;
        w[B_CNT_RST] = 1'b1;
        w[B_CLR_A]   = 1'b1;
        w[B_LOAD_X]  = 1'b1;
      end
      S_LOADR: begin
        w[B_LOAD_RH] = 1'b1;
        w[B_LOAD_RL] = 1'b1;
      end
      S_ADD: begin
        w[B_RH_HI]   = 1'b1;
        w[B_LOAD_RH] = 1'b1;
        // The final iteration weights the multiplier sign bit negatively.
        w[B_ADD]     = (it != 3'd7);
      end
      S_SHIFT: begin
        w[B_ARITH]   = 1'b1;
        w[B_SHIFT]   = 1'b1;
      end
      S_WRITE: begin
        w[B_RH_LO]   = 1'b1;
        w[B_RL_MUX]  = 1'b1;
        w[B_LOAD_RH] = 1'b1;
        w[B_LOAD_RL] = 1'b1;
      end
      S_STORE: begin
        w[B_LOAD_A]  = 1'b1;
        w[B_LOAD_X]  = 1'b1;
        w[B_X_MUX]   = 1'b1;
        w[B_CNT_EN]  = 1'b1;
      end
      default: w = 15'd0;
    endcase
    return w;
  endfunction

  // Next-state and iteration update
  always_comb begin
    state_d = S_IDLE;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_INIT;
        else           state_d = S_IDLE;
      end
      S_INIT: begin
        state_d = S_LOADR;
        iter_d  = 3'd0;
      end
      S_LOADR: state_d = S_TEST;
      S_TEST: begin
        if (bus.zr) state_d = S_SHIFT;
        else        state_d = S_ADD;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_WRITE;
      S_WRITE: state_d = S_STORE;
      S_STORE: state_d = S_CHECK;
      S_CHECK: begin
        if (bus.zq) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOADR;
          iter_d  = iter_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    c_d     = ctrl_word(state_d, iter_d);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, iteration and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= 3'd0;
      c_q     <= 15'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.c     = c_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

`ifdef ROBS_CTRL_CYCLES_EN
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] cycles_q, cycles_d;

  // Busy-cycle counter; INIT counts as the first cycle of the operation
  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    case (state_q)
      S_INIT: cnt_d = 6'd1;
      S_LOADR, S_TEST, S_ADD, S_SHIFT, S_WRITE, S_STORE, S_CHECK:
        cnt_d = cnt_q + 6'd1;
      default: cnt_d = cnt_q;
    endcase
    if ((state_q == S_CHECK) && bus.zq) cycles_d = cnt_q + 6'd1;
    else                                cycles_d = cycles_q;
  end

  // Counter and captured count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 6'd0;
      cycles_q <= 6'd0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.cycles = cycles_q;
`endif

endmodule
